// File: rtl/mtc_rx_pkg.sv
// Shared types and helpers for the MTC2SL sector-logic receiver.
// A packet word is MTC2SL_LEN bits wide; its MSB marks the slot as carrying a packet.
package mtc_rx_pkg;

  localparam int MTC2SL_LEN    = 32;
  localparam int MTC_PKT_LEN   = MTC2SL_LEN - 1;
  localparam int MTC_VALID_BIT = MTC2SL_LEN - 1;
  localparam int MAX_SLOTS     = 32;

  typedef logic [MTC_PKT_LEN-1:0] mtc_pkt_t;

  // Number of set bits in a slot-valid vector (callers zero-extend to MAX_SLOTS).
  function automatic logic [5:0] popcount(input logic [MAX_SLOTS-1:0] vec);
    logic [5:0] cnt;
    cnt = 6'd0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      cnt = cnt + {5'd0, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/mtc_rx_fifo.sv
// N-write / 1-read packet FIFO: packs valid write slots into consecutive entries,
// limits writes to the free space of the cycle, and presents the head first-word-fall-through.
module mtc_rx_fifo
  import mtc_rx_pkg::*;
#(
  parameter int N_WR  = 3,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       srst,
  input  logic [N_WR-1:0]            wr_valid,
  input  mtc_pkt_t [N_WR-1:0]        wr_data,
  output logic [$clog2(DEPTH):0]     wr_count,
  output mtc_pkt_t                   rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  mtc_pkt_t                    mem_r [DEPTH];
  logic [PTR_W-1:0]            wr_ptr_r;
  logic [PTR_W-1:0]            rd_ptr_r;
  logic [CW-1:0]               count_r;
  logic                        pop_s;
  logic [CW-1:0]               free_s;
  logic [CW-1:0]               wr_count_s;
  logic [N_WR-1:0]             wen_s;
  logic [N_WR-1:0][PTR_W-1:0]  waddr_s;

  assign rd_valid = (count_r != {CW{1'b0}});
  assign rd_data  = rd_valid ? mem_r[rd_ptr_r] : {MTC_PKT_LEN{1'b0}};
  assign pop_s    = rd_valid & rd_ready;
  // A pop in the same cycle frees its entry for this cycle's writes.
  assign free_s   = CW'(DEPTH) - count_r + {{(CW-1){1'b0}}, pop_s};
  assign wr_count = wr_count_s;
  assign count    = count_r;

  // Rank valid slots in index order; ranks at or beyond the free space are dropped.
  always_comb begin
    logic [CW-1:0] rank_v;
    rank_v  = {CW{1'b0}};
    wen_s   = {N_WR{1'b0}};
    waddr_s = {(N_WR*PTR_W){1'b0}};
    for (int i = 0; i < N_WR; i++) begin
      waddr_s[i] = wr_ptr_r + rank_v[PTR_W-1:0];
      if (wr_valid[i] && (rank_v < free_s)) begin
        wen_s[i] = 1'b1;
        rank_v   = rank_v + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        wen_s[i] = 1'b0;
      end
    end
    wr_count_s = rank_v;
  end

  // Storage array; contents past the read pointer are never observed, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_WR; i++) begin
      if (wen_s[i]) begin
        mem_r[waddr_s[i]] <= wr_data[i];
      end
    end
  end

  // Pointers and occupancy; pointers wrap naturally, full/empty come from count_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (srst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + wr_count_s[PTR_W-1:0];
      rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, pop_s};
      count_r  <= count_r + wr_count_s - {{(CW-1){1'b0}}, pop_s};
    end
  end

endmodule

// File: rtl/mtc_sl_receiver.sv
// Sector-logic receiver for MTC2SL packets: buffers up to n_PRIMARY_MTC packets per clk and
// streams them out one per cycle. Define MTC_RX_STATS_EN to add in/out/peak statistics ports.
module mtc_sl_receiver
  import mtc_rx_pkg::*;
#(
  parameter int n_PRIMARY_MTC = 3,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     srst,
  input  logic [n_PRIMARY_MTC-1:0][MTC2SL_LEN-1:0] mtc,
  output logic [MTC_PKT_LEN-1:0]                   pkt_o,
  output logic                                     pkt_valid_o,
  input  logic                                     pkt_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]              fifo_count_o,
  output logic                                     overflow_o,
  output logic [CNT_WIDTH-1:0]                     drop_count_o
`ifdef MTC_RX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]                     pkt_in_count_o,
  output logic [CNT_WIDTH-1:0]                     pkt_out_count_o,
  output logic [$clog2(FIFO_DEPTH):0]              peak_count_o
`endif
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int SUM_W = ((CNT_WIDTH > CW) ? CNT_WIDTH : CW) + 1;

  logic [n_PRIMARY_MTC-1:0]    valid_s;
  mtc_pkt_t [n_PRIMARY_MTC-1:0] data_s;
  logic [CW-1:0]               nvalid_s;
  logic [CW-1:0]               wr_count_s;
  logic [CW-1:0]               drop_s;
  logic [CW-1:0]               count_s;
  logic                        overflow_r;
  logic [CNT_WIDTH-1:0]        drop_cnt_r;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] acc,
                                                   input logic [CW-1:0]        inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(acc) + SUM_W'(inc);
    if (sum > SUM_W'({CNT_WIDTH{1'b1}})) begin
      return {CNT_WIDTH{1'b1}};
    end else begin
      return sum[CNT_WIDTH-1:0];
    end
  endfunction

  // Split each slot into its valid flag and payload.
  always_comb begin
    for (int i = 0; i < n_PRIMARY_MTC; i++) begin
      valid_s[i] = mtc[i][MTC_VALID_BIT];
      data_s[i]  = mtc[i][MTC_PKT_LEN-1:0];
    end
  end

  assign nvalid_s = CW'(popcount(MAX_SLOTS'(valid_s)));
  assign drop_s   = nvalid_s - wr_count_s;

  mtc_rx_fifo #(
    .N_WR  (n_PRIMARY_MTC),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .srst     (srst),
    .wr_valid (valid_s),
    .wr_data  (data_s),
    .wr_count (wr_count_s),
    .rd_data  (pkt_o),
    .rd_valid (pkt_valid_o),
    .rd_ready (pkt_ready_i),
    .count    (count_s)
  );

  assign fifo_count_o = count_s;
  assign overflow_o   = overflow_r;
  assign drop_count_o = drop_cnt_r;

  // Drop accounting: saturating counter plus a flag that sticks until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (srst) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      overflow_r <= overflow_r | (drop_s != {CW{1'b0}});
      drop_cnt_r <= sat_add(drop_cnt_r, drop_s);
    end
  end

`ifdef MTC_RX_STATS_EN
  logic                 pop_s;
  logic [CW-1:0]        count_next_s;
  logic [CNT_WIDTH-1:0] in_cnt_r;
  logic [CNT_WIDTH-1:0] out_cnt_r;
  logic [CW-1:0]        peak_r;

  assign pop_s        = pkt_valid_o & pkt_ready_i;
  // Peak tracks the next occupancy so it lines up with fifo_count_o.
  assign count_next_s = count_s + wr_count_s - {{(CW-1){1'b0}}, pop_s};

  // Throughput statistics and high-water mark.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_r  <= {CNT_WIDTH{1'b0}};
      out_cnt_r <= {CNT_WIDTH{1'b0}};
      peak_r    <= {CW{1'b0}};
    end else if (srst) begin
      in_cnt_r  <= {CNT_WIDTH{1'b0}};
      out_cnt_r <= {CNT_WIDTH{1'b0}};
      peak_r    <= {CW{1'b0}};
    end else begin
      in_cnt_r  <= sat_add(in_cnt_r, wr_count_s);
      out_cnt_r <= sat_add(out_cnt_r, {{(CW-1){1'b0}}, pop_s});
      peak_r    <= (count_next_s > peak_r) ? count_next_s : peak_r;
    end
  end

  assign pkt_in_count_o  = in_cnt_r;
  assign pkt_out_count_o = out_cnt_r;
  assign peak_count_o    = peak_r;
`endif

endmodule

// File: tb/tb_mtc_sl_receiver.sv
// Directed self-checking bench for mtc_sl_receiver (3 slots, depth 16, 4-bit counters).
module tb_mtc_sl_receiver;

  logic             clk;
  logic             rst;
  logic             srst;
  logic [2:0][31:0] mtc;
  logic [30:0]      pkt_o;
  logic             pkt_valid_o;
  logic             pkt_ready_i;
  logic [4:0]       fifo_count_o;
  logic             overflow_o;
  logic [3:0]       drop_count_o;
`ifdef MTC_RX_STATS_EN
  logic [3:0]       pkt_in_count_o;
  logic [3:0]       pkt_out_count_o;
  logic [4:0]       peak_count_o;
`endif

  int checks_cnt;
  int errors_cnt;

  mtc_sl_receiver #(
    .n_PRIMARY_MTC (3),
    .FIFO_DEPTH    (16),
    .CNT_WIDTH     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .srst         (srst),
    .mtc          (mtc),
    .pkt_o        (pkt_o),
    .pkt_valid_o  (pkt_valid_o),
    .pkt_ready_i  (pkt_ready_i),
    .fifo_count_o (fifo_count_o),
    .overflow_o   (overflow_o),
    .drop_count_o (drop_count_o)
`ifdef MTC_RX_STATS_EN
    ,
    .pkt_in_count_o  (pkt_in_count_o),
    .pkt_out_count_o (pkt_out_count_o),
    .peak_count_o    (peak_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic v, input logic [30:0] p);
    return {v, p};
  endfunction

  // Push n packets base+0..base+n-1, three per cycle, with no pop.
  task automatic fill(input int n, input logic [30:0] base);
    int k;
    k = 0;
    while (k < n) begin
      for (int s = 0; s < 3; s++) begin
        mtc[s] = (k + s < n) ? mk(1'b1, base + 31'(k + s)) : 32'd0;
      end
      k = k + 3;
      step();
    end
    mtc = '0;
  endtask

  logic [30:0] exp_v;

  initial begin
    checks_cnt  = 0;
    errors_cnt  = 0;
    rst         = 1'b0;
    srst        = 1'b0;
    mtc         = '0;
    pkt_ready_i = 1'b1;
    #12;
    check_eq("rst_valid", pkt_valid_o, 1'b0);
    check_eq("rst_pkt", pkt_o, 31'd0);
    check_eq("rst_count", fifo_count_o, 5'd0);
    check_eq("rst_ovf", overflow_o, 1'b0);
    check_eq("rst_drop", drop_count_o, 4'd0);
    rst = 1'b1;
    step();

    // 1: single packet in slot 1, invalid slots carry junk
    mtc[0] = mk(1'b0, 31'h7FFF0000);
    mtc[1] = mk(1'b1, 31'h5A5A1234);
    mtc[2] = mk(1'b0, 31'h1111);
    step();
    mtc = '0;
    check_eq("t1_valid", pkt_valid_o, 1'b1);
    check_eq("t1_pkt", pkt_o, 31'h5A5A1234);
    check_eq("t1_count", fifo_count_o, 5'd1);
    step();
    check_eq("t1_empty", pkt_valid_o, 1'b0);
    check_eq("t1_count0", fifo_count_o, 5'd0);
`ifdef MTC_RX_STATS_EN
    check_eq("t1_in", pkt_in_count_o, 4'd1);
    check_eq("t1_out", pkt_out_count_o, 4'd1);
`endif

    // 2: packing A,_,C then D,E,F
    mtc[0] = mk(1'b1, 31'hA);
    mtc[1] = mk(1'b0, 31'hBBB);
    mtc[2] = mk(1'b1, 31'hC);
    step();
    check_eq("t2_headA", pkt_o, 31'hA);
    check_eq("t2_cnt2", fifo_count_o, 5'd2);
    mtc[0] = mk(1'b1, 31'hD);
    mtc[1] = mk(1'b1, 31'hE);
    mtc[2] = mk(1'b1, 31'hF);
    step();
    mtc = '0;
    check_eq("t2_headC", pkt_o, 31'hC);
    check_eq("t2_cnt4", fifo_count_o, 5'd4);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t2_order", pkt_o, 31'hD + 31'(i));
      check_eq("t2_cnt", fifo_count_o, 5'd3 - 5'(i));
    end
    step();
    check_eq("t2_empty", pkt_valid_o, 1'b0);

    // 3: backpressure, fill to 16, hold, drain
    pkt_ready_i = 1'b0;
    fill(16, 31'h100);
    check_eq("t3_full", fifo_count_o, 5'd16);
    check_eq("t3_head", pkt_o, 31'h100);
    check_eq("t3_nodrop", drop_count_o, 4'd0);
    step();
    step();
    check_eq("t3_stable", pkt_o, 31'h100);
    check_eq("t3_stable_v", pkt_valid_o, 1'b1);
    pkt_ready_i = 1'b1;
    for (int k = 1; k < 16; k++) begin
      step();
      check_eq("t3_drain", pkt_o, 31'h100 + 31'(k));
      check_eq("t3_dcount", fifo_count_o, 5'd16 - 5'(k));
    end
    step();
    check_eq("t3_empty", pkt_valid_o, 1'b0);

    // 4: overflow without and with a same-cycle pop
    pkt_ready_i = 1'b0;
    fill(15, 31'h200);
    check_eq("t4_cnt15", fifo_count_o, 5'd15);
    mtc[0] = mk(1'b1, 31'h300);
    mtc[1] = mk(1'b1, 31'h301);
    mtc[2] = mk(1'b1, 31'h302);
    step();
    mtc = '0;
    check_eq("t4_cnt16", fifo_count_o, 5'd16);
    check_eq("t4_drop2", drop_count_o, 4'd2);
    check_eq("t4_ovf", overflow_o, 1'b1);
    pkt_ready_i = 1'b1;
    step();
    check_eq("t4_pop", fifo_count_o, 5'd15);
    mtc[0] = mk(1'b1, 31'h310);
    mtc[1] = mk(1'b1, 31'h311);
    mtc[2] = mk(1'b1, 31'h312);
    step();
    mtc = '0;
    check_eq("t4_cnt16b", fifo_count_o, 5'd16);
    check_eq("t4_drop3", drop_count_o, 4'd3);
    for (int i = 0; i < 16; i++) begin
      if (i < 13) exp_v = 31'h202 + 31'(i);
      else if (i == 13) exp_v = 31'h300;
      else if (i == 14) exp_v = 31'h310;
      else exp_v = 31'h311;
      check_eq("t4_order", pkt_o, exp_v);
      step();
    end
    check_eq("t4_empty", pkt_valid_o, 1'b0);
    check_eq("t4_ovf_hold", overflow_o, 1'b1);

    // 5: async reset mid-drain, then soft reset
    pkt_ready_i = 1'b0;
    fill(7, 31'h400);
    check_eq("t5_cnt7", fifo_count_o, 5'd7);
    pkt_ready_i = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    check_eq("t5_arst_v", pkt_valid_o, 1'b0);
    check_eq("t5_arst_pkt", pkt_o, 31'd0);
    check_eq("t5_arst_cnt", fifo_count_o, 5'd0);
    check_eq("t5_arst_ovf", overflow_o, 1'b0);
    check_eq("t5_arst_drop", drop_count_o, 4'd0);
    #2;
    rst = 1'b1;
    step();
    check_eq("t5_post_cnt", fifo_count_o, 5'd0);
    pkt_ready_i = 1'b0;
    fill(3, 31'h500);
    check_eq("t5_cnt3", fifo_count_o, 5'd3);
    srst = 1'b1;
    step();
    srst = 1'b0;
    check_eq("t5_srst_cnt", fifo_count_o, 5'd0);
    check_eq("t5_srst_v", pkt_valid_o, 1'b0);
    pkt_ready_i = 1'b1;
    mtc[2] = mk(1'b1, 31'h5AA);
    step();
    mtc = '0;
    check_eq("t5_pass_v", pkt_valid_o, 1'b1);
    check_eq("t5_pass_pkt", pkt_o, 31'h5AA);
    step();
    check_eq("t5_pass_empty", pkt_valid_o, 1'b0);

    // 6: drop counter saturation
    srst = 1'b1;
    step();
    srst = 1'b0;
    pkt_ready_i = 1'b0;
    fill(16, 31'h600);
    for (int c = 0; c < 7; c++) begin
      for (int s = 0; s < 3; s++) mtc[s] = mk(1'b1, 31'h700 + 31'(c * 3 + s));
      step();
      if (c == 3) check_eq("t6_drop12", drop_count_o, 4'd12);
    end
    mtc = '0;
    check_eq("t6_sat", drop_count_o, 4'd15);
    check_eq("t6_ovf", overflow_o, 1'b1);
    check_eq("t6_cnt", fifo_count_o, 5'd16);
    check_eq("t6_head", pkt_o, 31'h600);
`ifdef MTC_RX_STATS_EN
    check_eq("t6_peak", peak_count_o, 5'd16);
    check_eq("t6_in_sat", pkt_in_count_o, 4'd15);
    check_eq("t6_out", pkt_out_count_o, 4'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
